// File: rtl/tt_hb_pkg.sv
// tt_hb_pkg: shared types and helpers for the multi-channel heartbeat.
// Holds the pattern-mode encoding and the breathe-mode triangle step.
package tt_hb_pkg;

  typedef enum logic [1:0] {
    HB_DIV     = 2'd0,
    HB_CHASE   = 2'd1,
    HB_BREATHE = 2'd2,
    HB_OFF     = 2'd3
  } hb_mode_e;

  // Triangle level is carried at a fixed width so the helper stays
  // parameter-free; callers zero-extend and slice back to PWM_BITS.
  localparam int TRI_W = 17;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic             dir;
    logic [TRI_W-1:0] lvl;
  } hb_tri_t;

  // One triangle step: bounce at lvl_max and at zero without dwelling on the peaks.
  function automatic hb_tri_t tri_next(input logic [TRI_W-1:0] lvl,
                                       input logic             dir,
                                       input logic [TRI_W-1:0] lvl_max);
    hb_tri_t r;
    r.dir = dir;
    r.lvl = lvl;
    if (dir == DIR_UP) begin
      if (lvl == lvl_max) begin
        r.dir = DIR_DOWN;
        r.lvl = lvl_max - TRI_W'(1);
      end else begin
        r.lvl = lvl + TRI_W'(1);
      end
    end else begin
      if (lvl == '0) begin
        r.dir = DIR_UP;
        r.lvl = TRI_W'(1);
      end else begin
        r.lvl = lvl - TRI_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_hb_prescaler.sv
// tt_hb_prescaler: free-running divide-by-2^DIV_LOG2 counter gated by en.
// tick is combinational and lands on the same edge the counter wraps.
module tt_hb_prescaler #(
  parameter int DIV_LOG2 = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [DIV_LOG2-1:0] pre,
  output logic                tick
);

  logic [DIV_LOG2-1:0] pre_reg;

  // Count enabled cycles; freeze when en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_reg <= '0;
    end else if (en) begin
      pre_reg <= pre_reg + DIV_LOG2'(1);
    end
  end

  assign pre  = pre_reg;
  assign tick = en & (&pre_reg);

endmodule

// File: rtl/tt_heartbeat_multi.sv
// tt_heartbeat_multi: multi-channel heartbeat with shared prescaler and
// selectable pattern (divide, chase, breathe, off) plus per-pad output enable.
// Optional macro TT_HB_INPUT_SYNC_EN: double-flop en/mode before use
// (input-to-output latency 3 cycles instead of 1).
module tt_heartbeat_multi
  import tt_hb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIV_LOG2 = 20,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] out_oe
);

  localparam logic [TRI_W-1:0] LVL_MAX = TRI_W'((1 << PWM_BITS) - 1);

  logic                en_use;
  hb_mode_e            mode_use;
  logic [DIV_LOG2-1:0] pre;
  logic                tick;

  logic [CHANNELS-1:0] beat_reg;
  logic [CHANNELS-1:0] chase_reg;
  logic [CHANNELS-1:0] chase_next;
  logic [PWM_BITS-1:0] lvl_reg;
  logic                dir_reg;
  hb_tri_t             tri_nxt;

  logic [CHANNELS-1:0] out_reg;
  logic [CHANNELS-1:0] out_next;
  logic [CHANNELS-1:0] out_oe_reg;
  logic                pwm_on;
  logic                unused_bits;

`ifdef TT_HB_INPUT_SYNC_EN
  logic       en_s1_reg;
  logic       en_s2_reg;
  logic [1:0] mode_s1_reg;
  logic [1:0] mode_s2_reg;

  // Two-flop synchroniser for the control inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_s1_reg   <= 1'b0;
      en_s2_reg   <= 1'b0;
      mode_s1_reg <= 2'd0;
      mode_s2_reg <= 2'd0;
    end else begin
      en_s1_reg   <= en;
      en_s2_reg   <= en_s1_reg;
      mode_s1_reg <= mode;
      mode_s2_reg <= mode_s1_reg;
    end
  end

  assign en_use   = en_s2_reg;
  assign mode_use = hb_mode_e'(mode_s2_reg);
`else
  assign en_use   = en;
  assign mode_use = hb_mode_e'(mode);
`endif

  tt_hb_prescaler #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_use),
    .pre   (pre),
    .tick  (tick)
  );

  // Rotate-left by one; the modulo index also covers the single-channel case.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chase
    assign chase_next[gi] = chase_reg[(gi + CHANNELS - 1) % CHANNELS];
  end

  assign tri_nxt = tri_next({{(TRI_W-PWM_BITS){1'b0}}, lvl_reg}, dir_reg, LVL_MAX);

  // Pattern state advances on every tick whatever mode is selected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_reg  <= '0;
      chase_reg <= CHANNELS'(1);
      lvl_reg   <= '0;
      dir_reg   <= DIR_UP;
    end else if (tick) begin
      beat_reg  <= beat_reg + CHANNELS'(1);
      chase_reg <= chase_next;
      lvl_reg   <= tri_nxt.lvl[PWM_BITS-1:0];
      dir_reg   <= tri_nxt.dir;
    end
  end

  assign pwm_on = (pre[PWM_BITS-1:0] < lvl_reg);

  // Output pattern mux; everything is forced low while disabled.
  always_comb begin
    out_next = '0;
    if (en_use) begin
      case (mode_use)
        HB_DIV:     out_next = beat_reg;
        HB_CHASE:   out_next = chase_reg;
        HB_BREATHE: out_next = {CHANNELS{pwm_on}};
        default:    out_next = '0;
      endcase
    end
  end

  // Register pad data and output-enable so mode switches cannot glitch the pads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg    <= '0;
      out_oe_reg <= '0;
    end else begin
      out_reg    <= out_next;
      out_oe_reg <= (en_use && (mode_use != HB_OFF)) ? '1 : '0;
    end
  end

  assign out    = out_reg;
  assign out_oe = out_oe_reg;

  // Upper prescaler bits and the widened triangle level are intentionally not consumed.
  assign unused_bits = ^{pre[DIV_LOG2-1:PWM_BITS], tri_nxt.lvl[TRI_W-1:PWM_BITS]};

endmodule
